// File: rtl/core_acc_mc.sv
// Multi-lane group accumulator with round-half-up shift, signed saturation and valid/ready output.
// Optional per-lane start bias is enabled by defining CORE_ACC_MC_BIAS_EN.
module core_acc_mc #(
    parameter int LANES       = 4,
    parameter int IDATA_WIDTH = 20,
    parameter int ODATA_BIT   = 16,
    parameter int CDATA_BIT   = 8,
    parameter int ACC_WIDTH   = IDATA_WIDTH + CDATA_BIT,
    parameter int SHIFT_BIT   = $clog2(ACC_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CDATA_BIT-1:0]         cfg_acc_num,
    input  logic [SHIFT_BIT-1:0]         cfg_shift,
    input  logic [LANES*IDATA_WIDTH-1:0] idata,
`ifdef CORE_ACC_MC_BIAS_EN
    input  logic [LANES*IDATA_WIDTH-1:0] bias,
`endif
    input  logic                         idata_valid,
    output logic                         idata_ready,
    output logic [LANES*ODATA_BIT-1:0]   odata,
    output logic [LANES-1:0]             odata_sat,
    output logic                         odata_valid,
    input  logic                         odata_ready,
    output logic                         busy
);

    localparam int RW = ACC_WIDTH + 2;
    localparam logic signed [RW-1:0] OMAX = signed'({{(RW-ODATA_BIT+1){1'b0}}, {(ODATA_BIT-1){1'b1}}});
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t                      state_q;
    logic [CDATA_BIT-1:0]        cnt_q, n_q, n_eff;
    logic [SHIFT_BIT-1:0]        s_q, s_eff;
    logic signed [ACC_WIDTH-1:0] acc_q [LANES];
    logic signed [ACC_WIDTH-1:0] acc_d [LANES];
    logic signed [ACC_WIDTH-1:0] base;
    logic [LANES*ODATA_BIT-1:0]  odata_q, res_d;
    logic [LANES-1:0]            sat_q, sat_d;
    logic                        odata_valid_q;
    logic                        accept, first, last;
    logic signed [RW-1:0]        rnd, rsum, rshf;

    assign idata_ready = !(odata_valid_q && !odata_ready);
    assign accept      = idata_valid && idata_ready;
    assign odata       = odata_q;
    assign odata_sat   = sat_q;
    assign odata_valid = odata_valid_q;
    assign busy        = (state_q != S_IDLE) || odata_valid_q;

    // The group result is computed from the post-beat sum so it registers on the last beat's edge.
    always_comb begin
        first = (state_q != S_ACC);
        n_eff = first ? ((cfg_acc_num == '0) ? CDATA_BIT'(1) : cfg_acc_num) : n_q;
        s_eff = first ? cfg_shift : s_q;
        last  = first ? (n_eff == CDATA_BIT'(1)) : ((cnt_q + CDATA_BIT'(1)) == n_q);
        rnd   = (s_eff == '0) ? '0 : (RW'(1) << (s_eff - SHIFT_BIT'(1)));
        res_d = '0;
        sat_d = '0;
        base  = '0;
        rsum  = '0;
        rshf  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef CORE_ACC_MC_BIAS_EN
            base = first ? ACC_WIDTH'(signed'(bias[l*IDATA_WIDTH +: IDATA_WIDTH])) : acc_q[l];
`else
            base = first ? '0 : acc_q[l];
`endif
            acc_d[l] = base + ACC_WIDTH'(signed'(idata[l*IDATA_WIDTH +: IDATA_WIDTH]));
            rsum     = RW'(acc_d[l]) + rnd;
            rshf     = rsum >>> s_eff;
            if (rshf > OMAX) begin
                res_d[l*ODATA_BIT +: ODATA_BIT] = OMAX[ODATA_BIT-1:0];
                sat_d[l] = 1'b1;
            end else if (rshf < OMIN) begin
                res_d[l*ODATA_BIT +: ODATA_BIT] = OMIN[ODATA_BIT-1:0];
                sat_d[l] = 1'b1;
            end else begin
                res_d[l*ODATA_BIT +: ODATA_BIT] = rshf[ODATA_BIT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            n_q           <= '0;
            s_q           <= '0;
            odata_q       <= '0;
            sat_q         <= '0;
            odata_valid_q <= 1'b0;
            for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            if (odata_valid_q && odata_ready) odata_valid_q <= 1'b0;
            if (accept) begin
                for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
                if (first) begin
                    n_q <= n_eff;
                    s_q <= s_eff;
                end
                if (last) begin
                    state_q       <= S_DONE;
                    cnt_q         <= '0;
                    odata_q       <= res_d;
                    sat_q         <= sat_d;
                    odata_valid_q <= 1'b1;
                end else begin
                    state_q <= S_ACC;
                    cnt_q   <= cnt_q + CDATA_BIT'(1);
                end
            end else if (state_q == S_DONE) begin
                state_q <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_core_acc_mc.sv
// Scoreboard bench for core_acc_mc: a reference model queues expected group results on accepted beats.
module tb_core_acc_mc;

    localparam int L  = 4;
    localparam int IW = 20;
    localparam int OW = 16;
    localparam int CW = 8;
    localparam int SW = $clog2(IW + CW);

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     cfg_acc_num;
    logic [SW-1:0]     cfg_shift;
    logic [L*IW-1:0]   idata;
    logic              idata_valid;
    logic              idata_ready;
    logic [L*OW-1:0]   odata;
    logic [L-1:0]      odata_sat;
    logic              odata_valid;
    logic              odata_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [L*OW-1:0] d;
        logic [L-1:0]    s;
    } exp_t;
    exp_t sb[$];

    core_acc_mc #(
        .LANES(L), .IDATA_WIDTH(IW), .ODATA_BIT(OW), .CDATA_BIT(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_acc_num(cfg_acc_num), .cfg_shift(cfg_shift),
        .idata(idata), .idata_valid(idata_valid), .idata_ready(idata_ready),
        .odata(odata), .odata_sat(odata_sat), .odata_valid(odata_valid),
        .odata_ready(odata_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [L*IW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic logic [L*OW-1:0] opack(input int a, input int b, input int c, input int d);
        return {OW'(d), OW'(c), OW'(b), OW'(a)};
    endfunction

    // Reference model: integer group sum, round-half-up, floor shift, clamp.
    longint m_acc [L];
    int     m_cnt = 0;
    int     m_n = 1;
    int     m_s = 0;
    initial begin
        exp_t   e;
        longint r;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0;
                sb.delete();
            end else if (idata_valid && idata_ready) begin
                if (m_cnt == 0) begin
                    m_n = (cfg_acc_num == 0) ? 1 : int'(cfg_acc_num);
                    m_s = int'(cfg_shift);
                    for (int l = 0; l < L; l++) m_acc[l] = 0;
                end
                for (int l = 0; l < L; l++) m_acc[l] += longint'(signed'(idata[l*IW +: IW]));
                m_cnt++;
                if (m_cnt == m_n) begin
                    e.d = '0;
                    e.s = '0;
                    for (int l = 0; l < L; l++) begin
                        r = m_acc[l] + ((m_s > 0) ? (longint'(1) << (m_s - 1)) : 0);
                        r = r >>> m_s;
                        if (r > 32767) begin r = 32767; e.s[l] = 1'b1; end
                        else if (r < -32768) begin r = -32768; e.s[l] = 1'b1; end
                        e.d[l*OW +: OW] = OW'(r);
                    end
                    sb.push_back(e);
                    m_cnt = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && odata_valid && odata_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected odata=%h sat=%b with empty queue", odata, odata_sat);
                end else begin
                    e = sb.pop_front();
                    if (odata !== e.d || odata_sat !== e.s) begin
                        errors++;
                        $display("FAIL sb_result odata=%h sat=%b expected odata=%h sat=%b",
                                 odata, odata_sat, e.d, e.s);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds valid until the beat is taken; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [L*IW-1:0] d);
        int t;
        idata       = d;
        idata_valid = 1'b1;
        #2;
        t = 0;
        while (!idata_ready && t < 100) begin
            @(posedge clk);
            #3;
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout idata_ready stuck at %b, required 1", idata_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idata_valid = 1'b0; odata_ready = 1'b1;
        cfg_acc_num = 8'd1; cfg_shift = '0; idata = '0;
        repeat (3) step();
        checks++; if (odata !== '0) begin errors++; $display("FAIL rst_odata got %h want 0", odata); end
        checks++; if (odata_sat !== '0) begin errors++; $display("FAIL rst_sat got %b want 0", odata_sat); end
        checks++; if (odata_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", odata_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (idata_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", idata_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        cfg_acc_num = 8'd5; cfg_shift = '0;
        for (int g = 0; g < 3; g++) begin
            for (int b = 0; b < 5; b++) begin
                send_beat(pack4(1, 1, 1, 1));
                idata_valid = 1'b0;
                if (b < 4) begin
                    checks++;
                    if (odata_valid !== 1'b0) begin errors++; $display("FAIL lat_early g%0d b%0d valid=%b want 0", g, b, odata_valid); end
                end else begin
                    checks++;
                    if (odata_valid !== 1'b1 || odata !== opack(5, 5, 5, 5)) begin
                        errors++; $display("FAIL lat_result g%0d valid=%b odata=%h want 1/%h", g, odata_valid, odata, opack(5, 5, 5, 5));
                    end
                    step();
                    checks++;
                    if (odata_valid !== 1'b0) begin errors++; $display("FAIL lat_pulse g%0d valid=%b want 0", g, odata_valid); end
                end
                repeat (10) step();
            end
        end
    endtask

    task automatic test_round();
        cfg_acc_num = 8'd4; cfg_shift = SW'(3);
        repeat (4) send_beat(pack4(3, -3, 5, 0));
        idata_valid = 1'b0;
        checks++;
        if (odata_valid !== 1'b1 || odata !== opack(2, -1, 3, 0) || odata_sat !== 4'b0000) begin
            errors++; $display("FAIL round valid=%b odata=%h sat=%b want 1/%h/0000", odata_valid, odata, odata_sat, opack(2, -1, 3, 0));
        end
        repeat (3) step();
    endtask

    task automatic test_saturate();
        cfg_acc_num = 8'd2; cfg_shift = '0;
        repeat (2) send_beat(pack4(20000, -20000, 0, 0));
        idata_valid = 1'b0;
        checks++;
        if (odata !== opack(32767, -32768, 0, 0) || odata_sat !== 4'b0011) begin
            errors++; $display("FAIL saturate odata=%h sat=%b want %h/0011", odata, odata_sat, opack(32767, -32768, 0, 0));
        end
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        cfg_acc_num = 8'd1; cfg_shift = '0;
        odata_ready = 1'b0;
        send_beat(pack4(11, 12, 13, 14));
        idata = pack4(21, 22, 23, 24);
        checks++;
        if (idata_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", idata_ready); end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (odata_valid !== 1'b1 || odata !== opack(11, 12, 13, 14) || idata_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold c%0d valid=%b odata=%h ready=%b want 1/%h/0", c, odata_valid, odata, idata_ready, opack(11, 12, 13, 14));
            end
            step();
        end
        odata_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            send_beat(pack4(10*k+1, 10*k+2, 10*k+3, 10*k+4));
            checks++;
            if (odata !== opack(10*k+1, 10*k+2, 10*k+3, 10*k+4)) begin
                errors++; $display("FAIL bp_next k%0d odata=%h want %h", k, odata, opack(10*k+1, 10*k+2, 10*k+3, 10*k+4));
            end
        end
        idata_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_cfg();
        cfg_acc_num = 8'd0; cfg_shift = '0;
        for (int b = 0; b < 3; b++) begin
            send_beat(pack4(7, 7, 7, 7));
            checks++;
            if (odata_valid !== 1'b1 || odata !== opack(7, 7, 7, 7)) begin
                errors++; $display("FAIL cfg_zero b%0d valid=%b odata=%h want 1/%h", b, odata_valid, odata, opack(7, 7, 7, 7));
            end
        end
        idata_valid = 1'b0;
        step();
        cfg_acc_num = 8'd5;
        send_beat(pack4(2, 2, 2, 2));
        cfg_acc_num = 8'd3;
        repeat (3) send_beat(pack4(2, 2, 2, 2));
        checks++;
        if (odata_valid !== 1'b0) begin errors++; $display("FAIL cfg_frozen valid=%b after 4 beats want 0", odata_valid); end
        send_beat(pack4(2, 2, 2, 2));
        idata_valid = 1'b0;
        checks++;
        if (odata_valid !== 1'b1 || odata !== opack(10, 10, 10, 10)) begin
            errors++; $display("FAIL cfg_frozen_sum valid=%b odata=%h want 1/%h", odata_valid, odata, opack(10, 10, 10, 10));
        end
        repeat (3) step();
    endtask

    task automatic test_reset_abort();
        cfg_acc_num = 8'd5; cfg_shift = '0;
        repeat (3) send_beat(pack4(1, 1, 1, 1));
        idata_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || odata_valid !== 1'b0) begin
            errors++; $display("FAIL abort_state busy=%b valid=%b want 0/0", busy, odata_valid);
        end
        repeat (5) send_beat(pack4(1, 1, 1, 1));
        idata_valid = 1'b0;
        checks++;
        if (odata_valid !== 1'b1 || odata !== opack(5, 5, 5, 5)) begin
            errors++; $display("FAIL abort_next valid=%b odata=%h want 1/%h", odata_valid, odata, opack(5, 5, 5, 5));
        end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        cfg_acc_num = 8'd2; cfg_shift = SW'(1);
        fork
            begin
                repeat (60) begin
                    odata_ready = 1'($urandom_range(1));
                    step();
                end
                odata_ready = 1'b1;
            end
            begin
                for (int b = 0; b < 20; b++)
                    send_beat(pack4(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                                    int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000));
                idata_valid = 1'b0;
            end
        join
        repeat (5) step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain pending=%0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round();
        test_saturate();
        test_backpressure();
        test_cfg();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_drain pending=%0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
